// File: rtl/video_pkg.sv
// Shared raster constants, RGB332 layout and raster flag decode for the DK video path.
// Latency: n/a (package). Backpressure: n/a.
package video_pkg;

    localparam int CNT_W  = 9;
    localparam int PAL_AW = 8;
    localparam int PAL_DW = 8;

    // Donkey Kong CRT raster, in pixel-clock units
    localparam logic [CNT_W-1:0] H_ACTIVE    = 9'd256;
    localparam logic [CNT_W-1:0] H_TOTAL     = 9'd384;
    localparam logic [CNT_W-1:0] HSYNC_START = 9'd280;
    localparam logic [CNT_W-1:0] HSYNC_LEN   = 9'd32;
    localparam logic [CNT_W-1:0] V_ACTIVE    = 9'd224;
    localparam logic [CNT_W-1:0] V_TOTAL     = 9'd264;
    localparam logic [CNT_W-1:0] VSYNC_START = 9'd240;
    localparam logic [CNT_W-1:0] VSYNC_LEN   = 9'd4;

    localparam logic [CNT_W-1:0] H_LAST    = H_TOTAL - 9'd1;
    localparam logic [CNT_W-1:0] V_LAST    = V_TOTAL - 9'd1;
    localparam logic [CNT_W-1:0] HSYNC_END = HSYNC_START + HSYNC_LEN;
    localparam logic [CNT_W-1:0] VSYNC_END = VSYNC_START + VSYNC_LEN;

    // 640x480 timing on the frame doubler's output side
    localparam logic [9:0] OUT_H_ACTIVE    = 10'd640;
    localparam logic [9:0] OUT_H_TOTAL     = 10'd800;
    localparam logic [9:0] OUT_HSYNC_START = 10'd656;
    localparam logic [9:0] OUT_HSYNC_LEN   = 10'd96;
    localparam logic [9:0] OUT_V_ACTIVE    = 10'd480;
    localparam logic [9:0] OUT_V_TOTAL     = 10'd525;
    localparam logic [9:0] OUT_VSYNC_START = 10'd490;
    localparam logic [9:0] OUT_VSYNC_LEN   = 10'd2;

    // RGB332 packing {b[1:0], g[2:0], r[2:0]}
    localparam int R_OFS = 0;
    localparam int R_W   = 3;
    localparam int G_OFS = 3;
    localparam int G_W   = 3;
    localparam int B_OFS = 6;
    localparam int B_W   = 2;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [G_W-1:0] g;
        logic [R_W-1:0] r;
    } rgb332_t;

    typedef struct packed {
        logic active;
        logic hblank;
        logic vblank;
        logic hsync_n;
        logic vsync_n;
        logic first;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_IDLE = '{active: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                             hsync_n: 1'b1, vsync_n: 1'b1, first: 1'b0};

    function automatic raster_flags_t raster_flags(input logic [CNT_W-1:0] h,
                                                   input logic [CNT_W-1:0] v);
        raster_flags_t f;
        f.hblank  = (h >= H_ACTIVE);
        f.vblank  = (v >= V_ACTIVE);
        f.active  = !f.hblank && !f.vblank;
        f.hsync_n = !((h >= HSYNC_START) && (h < HSYNC_END));
        f.vsync_n = !((v >= VSYNC_START) && (v < VSYNC_END));
        f.first   = (h == '0) && (v == '0);
        return f;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// 256x8 palette: one synchronous write port, one registered read port.
// Latency: read data valid 1 cycle after re; read-first on same-address collision. Backpressure: none.
module palette_ram
    import video_pkg::*;
(
    input  logic              masterclk,
    input  logic              we,
    input  logic [PAL_AW-1:0] waddr,
    input  logic [PAL_DW-1:0] wdata,
    input  logic              re,
    input  logic [PAL_AW-1:0] raddr,
    output logic [PAL_DW-1:0] rdata
);

    logic [PAL_DW-1:0] mem [0:(1<<PAL_AW)-1];

    always_ff @(posedge masterclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read samples the pre-write contents: read-first
    always_ff @(posedge masterclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dk_video_timing.sv
// DK 384x264 raster generator with palette lookup to RGB332; optional colour bars under VIDEO_TESTPATTERN_EN.
// Latency: 2 pix_ce from counter value to output. Backpressure: none, free-running on pix_ce.
module dk_video_timing
    import video_pkg::*;
(
    input  logic             masterclk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    input  logic [7:0]       pix_idx,
    input  logic             pal_we,
    input  logic [7:0]       pal_addr,
    input  logic [7:0]       pal_wdata,
    input  logic             test_en,
    output logic             out_valid,
    output logic [2:0]       out_r,
    output logic [2:0]       out_g,
    output logic [1:0]       out_b,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             frame_start
);

    raster_flags_t s1_flags;
    raster_flags_t s2_flags;
    logic [7:0]    s1_idx;
    logic [7:0]    s1_idx_d;
    logic [7:0]    pal_q;
    rgb332_t       px;

    // Reset lands in vertical blank so the frame doubler sees a clean frame start
    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= V_ACTIVE;
        end else if (pix_ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 9'd1;
            end else begin
                hcount <= hcount + 9'd1;
            end
        end
    end

`ifdef VIDEO_TESTPATTERN_EN
    always_comb begin
        s1_idx_d = pix_idx;
        if (test_en) begin
            s1_idx_d = {hcount[7:5], hcount[7:5], hcount[7:6]};
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;

    always_comb begin
        s1_idx_d = pix_idx;
    end
`endif

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            s1_flags    <= FLAGS_IDLE;
            s1_idx      <= '0;
            s2_flags    <= FLAGS_IDLE;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && s1_flags.first;
            if (pix_ce) begin
                s1_flags <= raster_flags(hcount, vcount);
                s1_idx   <= s1_idx_d;
                s2_flags <= s1_flags;
            end
        end
    end

    // The palette's read register doubles as the S2 colour register
    palette_ram u_palette (
        .masterclk (masterclk),
        .we        (pal_we),
        .waddr     (pal_addr),
        .wdata     (pal_wdata),
        .re        (pix_ce),
        .raddr     (s1_idx),
        .rdata     (pal_q)
    );

    assign px        = rgb332_t'(pal_q);
    assign out_valid = s2_flags.active;
    assign out_r     = s2_flags.active ? px.r : '0;
    assign out_g     = s2_flags.active ? px.g : '0;
    assign out_b     = s2_flags.active ? px.b : '0;
    assign hblank    = s2_flags.hblank;
    assign vblank    = s2_flags.vblank;
    assign hsync_n   = s2_flags.hsync_n;
    assign vsync_n   = s2_flags.vsync_n;

endmodule

// File: tb/tb_dk_video_timing.sv
// Directed bench for dk_video_timing with a scoreboard of expected pixel records.
`timescale 1ns/1ps
module tb_dk_video_timing;

    logic       masterclk = 1'b0;
    logic       rst       = 1'b1;
    logic       pix_ce    = 1'b0;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic [7:0] pix_idx   = 8'h00;
    logic       pal_we    = 1'b0;
    logic [7:0] pal_addr  = 8'h00;
    logic [7:0] pal_wdata = 8'h00;
    logic       test_en   = 1'b0;
    logic       out_valid;
    logic [2:0] out_r;
    logic [2:0] out_g;
    logic [1:0] out_b;
    logic       hblank, vblank, hsync_n, vsync_n, frame_start;

    always #5 masterclk = ~masterclk;

    dk_video_timing dut (
        .masterclk   (masterclk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .hcount      (hcount),
        .vcount      (vcount),
        .pix_idx     (pix_idx),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .test_en     (test_en),
        .out_valid   (out_valid),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .hblank      (hblank),
        .vblank      (vblank),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic       valid;
        logic       hb;
        logic       vb;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
        logic [7:0] idx;
    } ent_t;

    localparam ent_t IDLE_ENT = '{valid: 1'b0, hb: 1'b1, vb: 1'b1, hs_n: 1'b1,
                                  vs_n: 1'b1, fs: 1'b0, idx: 8'h00};

    ent_t       q[$];
    logic [7:0] pal_m [256];
    int         hm, vm;
    int         checks = 0;
    int         errors = 0;
    int         valid_seen = 0;

    wire [31:0] obs = {out_valid, out_b, out_g, out_r, hblank, vblank, hsync_n, vsync_n,
                       frame_start, hcount, vcount};

    function automatic ent_t mk_ent(input int h, input int v, input logic [7:0] idx);
        ent_t e;
        e.valid = (h < 256) && (v < 224);
        e.hb    = (h >= 256);
        e.vb    = (v >= 224);
        e.hs_n  = !((h >= 280) && (h < 312));
        e.vs_n  = !((v >= 240) && (v < 244));
        e.fs    = (h == 0) && (v == 0);
        e.idx   = idx;
        return e;
    endfunction

    function automatic logic [31:0] exp_vec(input ent_t e, input logic [7:0] rgb,
                                            input logic fs, input int h, input int v);
        return {e.valid, rgb, e.hb, e.vb, e.hs_n, e.vs_n, fs, 9'(h), 9'(v)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic model_reset();
        hm = 0;
        vm = 224;
        q.delete();
        q.push_back(IDLE_ENT);
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge masterclk);
        pal_we = 1'b1; pal_addr = a; pal_wdata = d;
        @(posedge masterclk);
        pal_m[a] = d;
        #1;
        pal_we = 1'b0;
    endtask

    // One pix_ce with optional concurrent palette write, followed by div-1 idle cycles
    task automatic step(input logic [7:0] idx, input int div, input logic we,
                        input logic [7:0] wa, input logic [7:0] wd);
        ent_t       e;
        logic [7:0] rgb;
        logic [7:0] midx;
        @(negedge masterclk);
        pix_idx = idx; pix_ce = 1'b1; pal_we = we; pal_addr = wa; pal_wdata = wd;
        midx = idx;
`ifdef VIDEO_TESTPATTERN_EN
        if (test_en) midx = {hm[7:5], hm[7:5], hm[7:6]};
`endif
        q.push_back(mk_ent(hm, vm, midx));
        e   = q.pop_front();
        rgb = e.valid ? pal_m[e.idx] : 8'h00;
        @(posedge masterclk);
        if (we) pal_m[wa] = wd;
        if (hm == 383) begin
            hm = 0;
            vm = (vm == 263) ? 0 : vm + 1;
        end else begin
            hm = hm + 1;
        end
        #1;
        pix_ce = 1'b0;
        pal_we = 1'b0;
        chk("pixel", obs, exp_vec(e, rgb, e.fs, hm, vm));
        if (out_valid === 1'b1) valid_seen++;
        for (int i = 1; i < div; i++) begin
            @(posedge masterclk);
            #1;
            chk("hold", obs, exp_vec(e, rgb, 1'b0, hm, vm));
        end
    endtask

    task automatic run_to(input int h, input int v, input int div);
        int n;
        n = 0;
        while (!(hm == h && vm == v) && n < 110000) begin
            step(8'($urandom_range(0, 255)), div, 1'b0, 8'h00, 8'h00);
            n++;
        end
        chk("run_to_bound", 32'(n < 110000), 32'd1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int vb_bad, vcnt, vmis, hs_first, hs_cnt;
        logic [31:0] rst_vec;
        rst_vec = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 9'd224};

        repeat (3) @(posedge masterclk);
        #1;
        chk("reset_state", obs, rst_vec);
        @(negedge masterclk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 256; i++) pal_write(8'(i), 8'(i));

        // First blank line with pix_ce every 4th cycle
        vb_bad = 0;
        for (int k = 0; k < 384; k++) begin
            step(8'($urandom_range(0, 255)), 4, 1'b0, 8'h00, 8'h00);
            if (vblank !== 1'b1 || out_valid !== 1'b0) vb_bad++;
        end
        chk("vblank_first_line", 32'(vb_bad), 32'd0);

        run_to(0, 0, 1);
        step(8'h11, 1, 1'b0, 8'h00, 8'h00);
        step(8'h12, 1, 1'b0, 8'h00, 8'h00);
        chk("first_valid_fs", {30'd0, out_valid, frame_start}, 32'd3);
        chk("no_early_valid", 32'(valid_seen), 32'd1);

        // Line 0 shape: output currently shows pixel (0,0)
        vcnt = 0; vmis = 0; hs_first = -1; hs_cnt = 0;
        for (int k = 0; k < 384; k++) begin
            if (out_valid === 1'b1) vcnt++;
            if (out_valid !== (k < 256)) vmis++;
            if (hsync_n === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            step(8'($urandom_range(0, 255)), 1, 1'b0, 8'h00, 8'h00);
        end
        chk("line_valid_count", 32'(vcnt), 32'd256);
        chk("line_valid_shape", 32'(vmis), 32'd0);
        chk("hsync_start", 32'(hs_first), 32'd280);
        chk("hsync_len", 32'(hs_cnt), 32'd32);

        // Palette lookup
        pal_write(8'h5A, 8'hC7);
        run_to(10, 20, 1);
        step(8'h5A, 1, 1'b0, 8'h00, 8'h00);
        step(8'h00, 1, 1'b0, 8'h00, 8'h00);
        chk("pal_5a", {24'd0, out_r, out_g, out_b}, {24'd0, 3'd7, 3'd0, 2'd3});

        // Write/read collision returns old data, then new data
        run_to(30, 20, 1);
        step(8'h33, 1, 1'b0, 8'h00, 8'h00);
        step(8'h01, 1, 1'b1, 8'h33, 8'h99);
        chk("collision_old", {24'd0, out_r, out_g, out_b}, {24'd0, 3'd3, 3'd6, 2'd0});
        step(8'h33, 1, 1'b0, 8'h00, 8'h00);
        step(8'h02, 1, 1'b0, 8'h00, 8'h00);
        chk("collision_new", {24'd0, out_r, out_g, out_b}, {24'd0, 3'd1, 3'd3, 2'd2});

        // Test-pattern select at hcount 0xA0
        run_to(160, 20, 1);
        test_en = 1'b1;
        step(8'h21, 1, 1'b0, 8'h00, 8'h00);
        step(8'h21, 1, 1'b0, 8'h00, 8'h00);
        test_en = 1'b0;
`ifdef VIDEO_TESTPATTERN_EN
        chk("testpattern", {24'd0, out_r, out_g, out_b}, {24'd0, 3'd6, 3'd6, 2'd2});
`else
        chk("test_en_ignored", {24'd0, out_r, out_g, out_b}, {24'd0, 3'd1, 3'd4, 2'd0});
`endif

        // Asynchronous reset mid-frame
        run_to(100, 100, 1);
        @(negedge masterclk);
        #2;
        rst = 1'b1;
        #1;
        chk("midframe_reset", obs, rst_vec);
        model_reset();
        @(negedge masterclk);
        rst = 1'b0;
        #1;
        chk("post_reset_vcount", {23'd0, vcount}, 32'd224);
        valid_seen = 0;
        run_to(0, 0, 1);
        chk("no_valid_after_reset", 32'(valid_seen), 32'd0);
        step(8'h40, 1, 1'b0, 8'h00, 8'h00);
        step(8'h41, 1, 1'b0, 8'h00, 8'h00);
        chk("refirst_valid_fs", {30'd0, out_valid, frame_start}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dk_video_timing.md
Name: dk_video_timing

Overview:
- Upstream of the frame doubler; runs in the masterclk domain.
- Generates the Donkey Kong CRT raster: 256x224 active inside a 384x264 total.
- Exports raster counters so the tile/sprite mixer can supply an 8-bit colour index per pixel.
- Resolves each index through a writable 256x8 palette RAM and emits RGB332 plus valid, blanking and sync, aligned for the frame doubler's input side.

Parameters:
H_ACTIVE, 256, active pixels per line
H_TOTAL, 384, pixels per line including blanking
HSYNC_START, 280, hcount at which hsync_n asserts
HSYNC_LEN, 32, hsync width in pixels
V_ACTIVE, 224, active lines per frame
V_TOTAL, 264, lines per frame including blanking
VSYNC_START, 240, vcount at which vsync_n asserts
VSYNC_LEN, 4, vsync width in lines

Ports:
masterclk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_ce  in  1  pixel clock enable, one masterclk cycle wide; all raster state advances only on pix_ce
hcount  out  9  current pixel column, 0..H_TOTAL-1
vcount  out  9  current line, 0..V_TOTAL-1
pix_idx  in  8  palette index from mixer for the (hcount,vcount) presented this pix_ce
pal_we  in  1  palette write strobe (any cycle, not gated by pix_ce)
pal_addr  in  8  palette write address
pal_wdata  in  8  palette write data {b[1:0],g[2:0],r[2:0]}
test_en  in  1  test-pattern select (used only with the optional feature)
out_valid  out  1  active pixel on out_r/g/b
out_r  out  3  red
out_g  out  3  green
out_b  out  2  blue
hblank  out  1  delayed horizontal blank
vblank  out  1  delayed vertical blank
hsync_n  out  1  active-low hsync, pipeline-aligned
vsync_n  out  1  active-low vsync, pipeline-aligned
frame_start  out  1  one-masterclk pulse when the first active pixel of a frame is output

Behaviour:
- Reset values:
  - hcount = 0 and vcount = V_ACTIVE, so the block leaves reset in VBLANK (required by the frame doubler).
  - out_valid = 0, out_r/g/b = 0, hblank = 1, vblank = 1, hsync_n = 1, vsync_n = 1, frame_start = 0.
  - Palette contents are not reset.
- Counters, on pix_ce:
  - hcount increments, wrapping at H_TOTAL-1 to 0.
  - On that wrap, vcount increments, wrapping at V_TOTAL-1 to 0.
  - Without pix_ce, all state holds.
- Pipeline: two pix_ce stages.
  - Stage 1 (S1): on pix_ce, latch pix_idx, active = (hcount < H_ACTIVE && vcount < V_ACTIVE), and raw blank/sync derived from the current counters.
  - Stage 2 (S2): on the next pix_ce, the registered palette read of the S1 index lands in out_r/g/b, and the S1 flags land in the output registers.
  - Total latency from counter value to output is 2 pix_ce.
- All outputs change only on a masterclk edge where pix_ce = 1, and are stable for the whole pix_ce interval.
- Outside active: out_r/g/b = 0 and out_valid = 0.
- Per frame, out_valid is high for exactly 256 consecutive pix_ce per line, on 224 lines: 57344 pixels.
- Sync timing:
  - hsync_n = 0 for hcount in [HSYNC_START, HSYNC_START+HSYNC_LEN).
  - vsync_n = 0 for vcount in [VSYNC_START, VSYNC_START+VSYNC_LEN).
  - Both are delayed through the same 2 stages.
- frame_start is high for the single masterclk cycle in which the output for pixel (0,0) is registered.
- Palette write:
  - Synchronous, one port; the read port is independent.
  - If a write and an S1 read hit the same address in the same cycle, the read returns old data (read-first).
- Reset mid-frame forces the reset values immediately; the pipeline is flushed and out_valid stays 0 until line 0 of the next frame.

Optional Feature:
- VIDEO_TESTPATTERN_EN
  - Defined: when test_en = 1, the S1 index is replaced by the colour-bar index {hcount[7:5], hcount[7:5], hcount[7:6]}, which bypasses the mixer but still goes through the palette. Timing is unchanged.
  - Undefined: test_en is ignored and pix_idx is always used.

Decomposition:
- Shared package video_pkg:
  - DK timing constants (active/total/sync values above) and the 640x480 output constants used by the frame doubler.
  - RGB332 field offsets and widths.
- Sub-module palette_ram: 256x8, write port plus a registered read port with read enable = pix_ce, read-first.

Test Plan:
- Reset, then pix_ce every 4th cycle -> vblank = 1 and out_valid = 0 for the first 40 lines; first out_valid rises with frame_start; 57344 valid pixels per frame.
- Line timing, one line -> out_valid high for 256 pix_ce, then low for 128; hsync_n low for exactly 32 pix_ce, starting 280 pix_ce after the first valid pixel.
- Palette: write pal[0x5A] = 0xC7, drive pix_idx = 0x5A at (10,20) -> 2 pix_ce later out_r = 7, out_g = 0, out_b = 3.
- Write/read collision on the same address in the same cycle -> old value output; new value output on the next access.
- Assert rst at (100,100) -> all outputs return to reset values at once; after release, vcount = 224 and the first valid pixel appears at the start of the next frame.
- VIDEO_TESTPATTERN_EN with test_en = 1, identity palette -> pixel at hcount = 0xA0 outputs index 0xB6 (r = 6, g = 6, b = 2).
